alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational CR-16 ALU between two requesters (0: CPU datapath, 1: aux/debug engine).
//  Round-robin arbitration, valid/ready request and response handshakes, registered result and flags.
//  Maintains the processor status flags (PSR) from flag-setting operations.
//  Sits between the requesters and the ALU; the ALU's select/a/b are driven only from this block.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width; must match the ALU's DATA_WIDTH
//  SEL_WIDTH   4   ALU function select width (ADD=0000, SUB=0001, others pass through)
// PORTS
//  clk         in   1           single clock, all state updates on rising edge
//  reset       in   1           synchronous, active-high
//  req0_valid  in   1           requester 0 has an operation
//  req0_ready  out  1           requester 0 op accepted this cycle (valid&&ready)
//  req0_a      in   DATA_WIDTH  operand a, requester 0
//  req0_b      in   DATA_WIDTH  operand b, requester 0
//  req0_sel    in   SEL_WIDTH   ALU select, requester 0
//  req1_*      --   --          identical set for requester 1
//  alu_a       out  DATA_WIDTH  to ALU a
//  alu_b       out  DATA_WIDTH  to ALU b
//  alu_select  out  SEL_WIDTH   to ALU select
//  alu_out     in   DATA_WIDTH  from ALU out
//  alu_flags   in   5           from ALU {C,L,F,Z,N}
//  rsp0_valid  out  1           result for requester 0 available
//  rsp0_ready  in   1           requester 0 consumes result
//  rsp1_valid  out  1           result for requester 1 available
//  rsp1_ready  in   1           requester 1 consumes result
//  rsp_data    out  DATA_WIDTH  registered result (shared by both responses)
//  rsp_flags   out  5           registered raw {C,L,F,Z,N} of that op
//  psr         out  5           status flags {C,L,F,Z,N} from last completed ADD/SUB
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (req0 priority), req*_ready=0, rsp*_valid=0, rsp_data=0,
//   rsp_flags=0, psr=0, latched op regs=0 (alu_a/alu_b/alu_select=0). Reset mid-op drops op, no response.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE: grant = (both valid) ? rr_ptr : whichever valid. reqG_ready=1 combinationally for granted
//   requester only (never both). On accept: latch a/b/sel/id, rr_ptr <= ~G, go ISSUE. No valid: stay.
//  ISSUE (1 cycle): alu_* driven from latched regs; at edge capture rsp_data<=alu_out,
//   rsp_flags<=alu_flags; if sel is ADD or SUB, psr<=alu_flags, else psr unchanged. Go RESP.
//  RESP: rsp<id>_valid=1 (other rsp valid=0) held until rsp<id>_ready; rsp_data/flags stable.
//   On handshake go IDLE; new request accepted no earlier than next cycle. rsp<other>_ready ignored.
//  Latency: accept in cycle T -> rsp_valid asserted in T+2; min 3 cycles per op (ready==1 in RESP).
//  req*_ready=0 in ISSUE/RESP; requesters hold valid and operands until accepted.
//  rr_ptr changes only on accept; single requester repeatedly valid is served back-to-back.
//  alu_* hold last latched values outside ISSUE (no glitching to ALU between ops).
//  Widths: no arithmetic here; data/flags passed unmodified; select passed as-is (unknown codes allowed).
// TESTING
//  1. reset held 2 cycles mid-RESP -> all outputs 0, rsp*_valid=0, psr=0, next grant goes to req0.
//  2. req0 ADD a=16'h7FFF b=16'h0001 -> ready at T, rsp0_valid at T+2, rsp_data=16'h8000, F=1, psr F=1.
//  3. req0 and req1 valid together repeatedly -> grants alternate 0,1,0,1; each rsp tagged to correct id.
//  4. req1 XOR 16'hFFFF,16'hFFFF after SUB 5-7 -> rsp_flags Z=1, psr keeps SUB flags (N=1, L=1).
//  5. rsp0_ready held low 10 cycles -> rsp0_valid and rsp_data stable, req1_ready stays 0 throughout.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two request channels, the ALU drive/return and
//   the two response channels of the shared-ALU arbiter.
// Ports (via modports): slave = arbiter side, master = requesters + ALU side.
//   req0_*/req1_* : valid/ready op channels with operands a/b and select
//   alu_*         : operands/select out to the ALU, result/flags back
//   rsp0_*/rsp1_* : valid/ready result channels; rsp_data/rsp_flags/psr shared
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [SEL_WIDTH-1:0]  req0_sel;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [SEL_WIDTH-1:0]  req1_sel;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [SEL_WIDTH-1:0]  alu_select;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [4:0]            alu_flags;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [4:0]            rsp_flags;
  logic [4:0]            psr;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req1_ready,
    output alu_a, alu_b, alu_select,
    input  alu_out, alu_flags,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_flags, psr,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req1_ready,
    input  alu_a, alu_b, alu_select,
    output alu_out, alu_flags,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_flags, psr,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: round-robin share of one combinational ALU between requester 0 (CPU) and 1 (aux/debug).
// Latency: op accepted in cycle T -> registered result with rsp_valid in T+2; 3 cycles min per op.
// Backpressure: req ready only in IDLE; response held stable until its own rsp_ready.
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus        : alu_arbiter_if.slave (request channels, ALU drive/return, response channels, psr)
module alu_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam logic [SEL_WIDTH-1:0] SEL_ADD = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] SEL_SUB = SEL_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic                  id;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } op_t;

  state_t state;
  op_t    op;
  logic   rr_ptr;     // requester that wins when both are valid
  logic   grant;
  logic   any_valid;

  assign any_valid = bus.req0_valid || bus.req1_valid;

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = rr_ptr;
    else                                  grant = bus.req1_valid;
  end

  // Ready is combinational so an op is accepted the same cycle it is granted.
  assign bus.req0_ready = (state == IDLE) && any_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && any_valid &&  grant;

  // ALU sees only the latched op, so its inputs never move between ops.
  assign bus.alu_a      = op.a;
  assign bus.alu_b      = op.b;
  assign bus.alu_select = op.sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op             <= '0;
      rr_ptr         <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_flags  <= '0;
      bus.psr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op.id  <= grant;
            op.a   <= grant ? bus.req1_a   : bus.req0_a;
            op.b   <= grant ? bus.req1_b   : bus.req0_b;
            op.sel <= grant ? bus.req1_sel : bus.req0_sel;
            rr_ptr <= ~grant;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          bus.rsp_data  <= bus.alu_out;
          bus.rsp_flags <= bus.alu_flags;
          // Only arithmetic ops define the processor status flags.
          if (op.sel == SEL_ADD || op.sel == SEL_SUB) bus.psr <= bus.alu_flags;
          bus.rsp0_valid <= !op.id;
          bus.rsp1_valid <=  op.id;
          state          <= RESP;
        end
        RESP: begin
          // Only the owning requester's ready completes the response.
          if (op.id ? bus.rsp1_ready : bus.rsp0_ready) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed ops with hand-computed results, a behavioural
// ALU model on the ALU side, and one check task for every comparison.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_arbiter_if #(.DATA_WIDTH(16), .SEL_WIDTH(4)) bus ();

  alu_arbiter #(.DATA_WIDTH(16), .SEL_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 6 XOR, anything else OR. Flags {C,L,F,Z,N}.
  logic [16:0] alu_wide;
  logic [15:0] alu_res;
  logic        alu_c, alu_l, alu_f;
  always_comb begin
    alu_wide = 17'd0;
    alu_res  = 16'd0;
    alu_c    = 1'b0;
    alu_l    = 1'b0;
    alu_f    = 1'b0;
    case (bus.alu_select)
      4'd0: begin
        alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_res  = alu_wide[15:0];
        alu_c    = alu_wide[16];
        alu_f    = (bus.alu_a[15] == bus.alu_b[15]) && (alu_res[15] != bus.alu_a[15]);
      end
      4'd1: begin
        alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        alu_res  = alu_wide[15:0];
        alu_c    = alu_wide[16];
        alu_l    = bus.alu_a < bus.alu_b;
        alu_f    = (bus.alu_a[15] != bus.alu_b[15]) && (alu_res[15] != bus.alu_a[15]);
      end
      4'd2:    alu_res = bus.alu_a & bus.alu_b;
      4'd6:    alu_res = bus.alu_a ^ bus.alu_b;
      default: alu_res = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_out   = alu_res;
    bus.alu_flags = {alu_c, alu_l, alu_f, (alu_res == 16'd0), alu_res[15]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge with requests already driven. Waits for a grant, follows
  // the op through ISSUE and RESP, optionally stalls the response, then completes it.
  // Returns at the negedge right after the response handshake (FSM back in IDLE).
  task automatic serve(input string tag, input logic exp_id,
                       input logic [15:0] exp_a, input logic [15:0] exp_b, input logic [3:0] exp_sel,
                       input logic [15:0] exp_data, input logic [4:0] exp_flags,
                       input logic [4:0] exp_psr, input int stall);
    int n;
    n = 0;
    #1;
    while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_grant_timeout"}, 32'(n >= 20), 32'd0);
    check({tag, "_grant_id"}, {31'd0, bus.req1_ready}, {31'd0, exp_id});
    check({tag, "_grant_onehot"}, {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);

    @(negedge clk);
    #1;
    check({tag, "_issue_rdy"}, {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
    check({tag, "_issue_rspv"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check({tag, "_alu_a"}, {16'd0, bus.alu_a}, {16'd0, exp_a});
    check({tag, "_alu_b"}, {16'd0, bus.alu_b}, {16'd0, exp_b});
    check({tag, "_alu_sel"}, {28'd0, bus.alu_select}, {28'd0, exp_sel});

    @(negedge clk);
    #1;
    check({tag, "_rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid},
          exp_id ? 32'd2 : 32'd1);
    check({tag, "_rsp_data"}, {16'd0, bus.rsp_data}, {16'd0, exp_data});
    check({tag, "_rsp_flags"}, {27'd0, bus.rsp_flags}, {27'd0, exp_flags});
    check({tag, "_psr"}, {27'd0, bus.psr}, {27'd0, exp_psr});

    // While stalled, the other requester's rsp_ready is raised and must be ignored.
    for (int i = 0; i < stall; i++) begin
      if (exp_id) bus.rsp0_ready = 1'b1;
      else        bus.rsp1_ready = 1'b1;
      @(negedge clk);
      #1;
      check({tag, "_stall_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid},
            exp_id ? 32'd2 : 32'd1);
      check({tag, "_stall_data"}, {16'd0, bus.rsp_data}, {16'd0, exp_data});
      check({tag, "_stall_rdy"}, {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
    end

    bus.rsp0_ready = !exp_id;
    bus.rsp1_ready =  exp_id;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check({tag, "_rsp_done"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_rspv",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check("rst_rdy",   {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check("rst_data",  {16'd0, bus.rsp_data}, 32'd0);
    check("rst_flags", {27'd0, bus.rsp_flags}, 32'd0);
    check("rst_psr",   {27'd0, bus.psr}, 32'd0);
    check("rst_alu",   {bus.alu_select, bus.alu_a[11:0], bus.alu_b}, 32'd0);
    reset = 1'b0;

    // ADD overflow from requester 0.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001; bus.req0_sel = 4'd0;
    serve("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 5'b00101, 5'b00101, 0);
    bus.req0_valid = 1'b0;

    // Reset held two cycles while a response is pending (rr_ptr was just moved to 1).
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_sel = 4'd0;
    #1;
    check("mid_acc", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_resp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("mrst_rspv",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check("mrst_data",  {16'd0, bus.rsp_data}, 32'd0);
    check("mrst_flags", {27'd0, bus.rsp_flags}, 32'd0);
    check("mrst_psr",   {27'd0, bus.psr}, 32'd0);
    check("mrst_alu",   {bus.alu_select, bus.alu_a[11:0], bus.alu_b}, 32'd0);
    reset = 1'b0;

    // Both requesters continuously valid: grants alternate starting at 0.
    bus.req0_valid = 1'b1; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h0002; bus.req0_sel = 4'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'hF0F0; bus.req1_b = 16'h0FF0; bus.req1_sel = 4'd2;
    #1;
    check("rr_first", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      serve("rr_r0", 1'b0, 16'hFFFF, 16'h0002, 4'd0, 16'h0001, 5'b10000, 5'b10000, 0);
      serve("rr_r1", 1'b1, 16'hF0F0, 16'h0FF0, 4'd2, 16'h00F0, 5'b00000, 5'b10000, 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // SUB then XOR from requester 1 back-to-back; XOR leaves psr alone.
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0005; bus.req1_b = 16'h0007; bus.req1_sel = 4'd1;
    serve("sub", 1'b1, 16'h0005, 16'h0007, 4'd1, 16'hFFFE, 5'b11001, 5'b11001, 0);
    bus.req1_a = 16'hFFFF; bus.req1_b = 16'hFFFF; bus.req1_sel = 4'd6;
    serve("xor", 1'b1, 16'hFFFF, 16'hFFFF, 4'd6, 16'h0000, 5'b00010, 5'b11001, 0);
    bus.req1_valid = 1'b0;

    // Response stall of 10 cycles with requester 1 waiting.
    bus.req0_valid = 1'b1; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001; bus.req0_sel = 4'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'hFFFF; bus.req1_b = 16'h1234; bus.req1_sel = 4'd2;
    serve("stall", 1'b0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 5'b00101, 5'b00101, 10);
    bus.req0_valid = 1'b0;
    serve("after", 1'b1, 16'hFFFF, 16'h1234, 4'd2, 16'h1234, 5'b00000, 5'b00101, 0);
    bus.req1_valid = 1'b0;

    // ALU inputs keep the last op while idle.
    repeat (3) @(negedge clk);
    #1;
    check("hold_alu_a",   {16'd0, bus.alu_a}, 32'h0000FFFF);
    check("hold_alu_b",   {16'd0, bus.alu_b}, 32'h00001234);
    check("hold_alu_sel", {28'd0, bus.alu_select}, 32'd2);
    check("idle_rdy",     {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
